// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LEN,
    ST_DATA,
    ST_CSUM
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  // A LEN byte of zero encodes a full 256-byte image.
  localparam bit LEN_ZERO_MEANS_256 = 1'b1;

  function automatic logic [8:0] len_decode(input logic [7:0] len);
    return (LEN_ZERO_MEANS_256 && (len == 8'd0)) ? 9'd256 : {1'b0, len};
  endfunction

endpackage

// File: rtl/loader_timeout.sv
// Inter-byte idle watchdog for the loader.
// Latency: expired is combinational from the count; the count reloads one cycle after reload.
// Backpressure: none, it only observes reload/enable strobes.
module loader_timeout #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic clock,
  input  logic reset,
  input  logic reload,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] RELOAD_VAL = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= RELOAD_VAL;
    end else if (reload) begin
      cnt <= RELOAD_VAL;
    end else if (enable && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // A byte in the same cycle as expiry wins: reload masks the flag.
  assign expired = enable && !reload && (cnt == '0);

endmodule

// File: rtl/instr_mem_loader.sv
// Parses SYNC/LEN/DATA[/CSUM] frames from the UART and writes instruction RAM while holding the CPU.
// Latency: one registered write (mem_we) the cycle after each data strobe; no backpressure, bytes are never stalled.
// LOADER_CHECKSUM_EN adds a trailing checksum byte that must zero the 8-bit sum of the image.
module instr_mem_loader
  import loader_pkg::*;
#(
  parameter int          ADDR_W         = 8,
  parameter int          DATA_W         = 8,
  parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEF,
  parameter int          BASE_ADDR      = 0,
  parameter int          TIMEOUT_CYCLES = 1000000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] ptr;
  logic [8:0]        remain;
  logic              in_frame, sync_hit, tmo_reload, expired;
  logic              do_start, do_write, do_done, do_err;

  assign in_frame   = (state != ST_IDLE);
  assign sync_hit   = rx_valid && (rx_data == SYNC_BYTE);
  assign tmo_reload = in_frame ? rx_valid : sync_hit;

  loader_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clock  (clock),
    .reset  (reset),
    .reload (tmo_reload),
    .enable (in_frame),
    .expired(expired)
  );

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] sum;
  logic [7:0] sum_chk;
  assign sum_chk = sum + rx_data;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sum <= 8'd0;
    end else if (do_start) begin
      sum <= 8'd0;
    end else if (do_write) begin
      sum <= sum_chk;
    end
  end
`endif

  always_comb begin
    state_nxt = state;
    do_start  = 1'b0;
    do_write  = 1'b0;
    do_done   = 1'b0;
    do_err    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (sync_hit) begin
          state_nxt = ST_LEN;
          do_start  = 1'b1;
        end
      end
      ST_LEN: begin
        if (rx_valid) begin
          state_nxt = ST_DATA;
        end else if (expired) begin
          state_nxt = ST_IDLE;
          do_err    = 1'b1;
        end
      end
      ST_DATA: begin
        if (rx_valid) begin
          do_write = 1'b1;
          if (remain == 9'd1) begin
`ifdef LOADER_CHECKSUM_EN
            state_nxt = ST_CSUM;
`else
            state_nxt = ST_IDLE;
            do_done   = 1'b1;
`endif
          end
        end else if (expired) begin
          state_nxt = ST_IDLE;
          do_err    = 1'b1;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      ST_CSUM: begin
        if (rx_valid) begin
          state_nxt = ST_IDLE;
          if (sum_chk == 8'd0) begin
            do_done = 1'b1;
          end else begin
            do_err  = 1'b1;
          end
        end else if (expired) begin
          state_nxt = ST_IDLE;
          do_err    = 1'b1;
        end
      end
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      ptr       <= BASE;
      remain    <= 9'd0;
      mem_we    <= 1'b0;
      mem_waddr <= BASE;
      mem_wdata <= '0;
      cpu_hold  <= 1'b0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      state     <= state_nxt;
      mem_we    <= do_write;
      load_done <= do_done;
      if (do_start) begin
        cpu_hold <= 1'b1;
        load_err <= 1'b0;
      end
      if ((state == ST_LEN) && rx_valid) begin
        remain <= len_decode(rx_data);
        ptr    <= BASE;
      end
      // Pointer wraps modulo the memory depth; a 256-byte image may cross the top.
      if (do_write) begin
        mem_waddr <= ptr;
        mem_wdata <= DATA_W'(rx_data);
        ptr       <= ptr + ADDR_W'(1);
        remain    <= remain - 9'd1;
      end
      if (do_done) begin
        cpu_hold <= 1'b0;
      end
      if (do_err) begin
        load_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: framing, wrap, timeout, checksum and async reset.
module tb_instr_mem_loader;

  localparam int TMO = 40;

  logic       clock = 1'b0;
  logic       reset;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       mem_we;
  logic [7:0] mem_waddr;
  logic [7:0] mem_wdata;
  logic       cpu_hold;
  logic       load_done;
  logic       load_err;

  instr_mem_loader #(
    .ADDR_W(8), .DATA_W(8), .SYNC_BYTE(8'hA5), .BASE_ADDR(0), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .mem_we   (mem_we),
    .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata),
    .cpu_hold (cpu_hold),
    .load_done(load_done),
    .load_err (load_err)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Write/done monitor feeding a RAM model.
  int         wr_cnt = 0;
  int         done_cnt = 0;
  logic [7:0] mdl [256];
  always @(negedge clock) begin
    if (mem_we === 1'b1) begin
      wr_cnt++;
      mdl[mem_waddr] = mem_wdata;
    end
    if (load_done === 1'b1) done_cnt++;
  end

  // Outputs observed on the cycle after the most recent strobe.
  logic       o_we, o_done, o_hold, o_err;
  logic [7:0] o_addr, o_data;

  task automatic send(input logic [7:0] b);
    @(negedge clock);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clock);
    #1;
    o_we   = mem_we;
    o_addr = mem_waddr;
    o_data = mem_wdata;
    o_done = load_done;
    o_hold = cpu_hold;
    o_err  = load_err;
    rx_valid = 1'b0;
    @(posedge clock);
  endtask

  task automatic finish_frame(input logic [7:0] s);
`ifdef LOADER_CHECKSUM_EN
    logic [7:0] c;
    c = 8'h00 - s;
    send(c);
`else
    if (s === 8'hxx) $display("bad sum");
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int         base, d0, k;
    logic [7:0] s;

    reset = 1'b1;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    #23;
    chk("rst_we", mem_we, 0);
    chk("rst_waddr", mem_waddr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_hold", cpu_hold, 0);
    chk("rst_done", load_done, 0);
    chk("rst_err", load_err, 0);
    @(negedge clock);
    reset = 1'b0;

    // Noise before SYNC is ignored.
    send(8'h12);
    send(8'h34);
    chk("noise_writes", wr_cnt, 0);
    chk("noise_hold", cpu_hold, 0);
    send(8'hA5);
    chk("sync_hold", o_hold, 1);

    // Basic three-byte image.
    send(8'h03);
    send(8'hCF);
    chk("b0_we", o_we, 1);
    chk("b0_addr", o_addr, 8'h00);
    chk("b0_data", o_data, 8'hCF);
    send(8'hDA);
    chk("b1_addr", o_addr, 8'h01);
    chk("b1_data", o_data, 8'hDA);
    send(8'h0B);
    chk("b2_addr", o_addr, 8'h02);
    chk("b2_data", o_data, 8'h0B);
    s = 8'hCF + 8'hDA + 8'h0B;
    finish_frame(s);
    chk("basic_done", o_done, 1);
    chk("basic_hold_fall", o_hold, 0);
    @(posedge clock);
    #1;
    chk("done_one_cycle", load_done, 0);
    chk("basic_writes", wr_cnt, 3);
    chk("basic_mem1", mdl[1], 8'hDA);

    // LEN=0 -> 256 bytes covering the whole address space.
    base = wr_cnt;
    d0 = done_cnt;
    send(8'hA5);
    send(8'h00);
    s = 8'h00;
    for (int i = 0; i < 256; i++) begin
      send(8'(i));
      s = s + 8'(i);
    end
    chk("full_last_addr", o_addr, 8'hFF);
    finish_frame(s);
    chk("full_done", o_done, 1);
    @(negedge clock);
    #1;
    chk("full_writes", wr_cnt - base, 256);
    chk("full_mem80", mdl[8'h80], 8'h80);
    chk("full_memff", mdl[8'hFF], 8'hFF);
    chk("full_done_cnt", done_cnt - d0, 1);

    // Timeout mid-frame.
    base = wr_cnt;
    send(8'hA5);
    send(8'h02);
    send(8'hC1);
    chk("tmo_w_addr", o_addr, 8'h00);
    repeat (TMO - 5) @(posedge clock);
    #1;
    chk("tmo_err_early", load_err, 0);
    k = 0;
    while (load_err !== 1'b1 && k < 20) begin
      @(posedge clock);
      #1;
      k++;
    end
    chk("tmo_err", load_err, 1);
    chk("tmo_hold", cpu_hold, 1);
    repeat (10) @(posedge clock);
    #1;
    chk("tmo_writes", wr_cnt - base, 1);
    chk("tmo_err_sticky", load_err, 1);
    send(8'hA5);
    chk("sync_clears_err", o_err, 0);
    send(8'h01);
    send(8'h77);
    finish_frame(8'h77);
    chk("recover_done", o_done, 1);
    chk("recover_hold", o_hold, 0);

`ifdef LOADER_CHECKSUM_EN
    send(8'hA5);
    send(8'h01);
    send(8'hC0);
    send(8'h00);
    chk("bad_csum_err", o_err, 1);
    chk("bad_csum_hold", o_hold, 1);
    chk("bad_csum_done", o_done, 0);
    send(8'hA5);
    send(8'h01);
    send(8'hC0);
    send(8'h40);
    chk("good_csum_done", o_done, 1);
    chk("good_csum_err", o_err, 0);
    chk("good_csum_hold", o_hold, 0);
`endif

    // Asynchronous reset in the middle of DATA.
    send(8'hA5);
    send(8'h04);
    send(8'h11);
    @(negedge clock);
    rx_valid = 1'b1;
    rx_data  = 8'h22;
    @(posedge clock);
    #1;
    rx_valid = 1'b0;
    chk("pre_rst_we", mem_we, 1);
    chk("pre_rst_addr", mem_waddr, 8'h01);
    #1;
    reset = 1'b1;
    #1;
    chk("arst_we", mem_we, 0);
    chk("arst_hold", cpu_hold, 0);
    chk("arst_waddr", mem_waddr, 0);
    chk("arst_wdata", mem_wdata, 0);
    @(negedge clock);
    reset = 1'b0;
    send(8'hA5);
    send(8'h02);
    send(8'h5A);
    chk("post_rst_addr0", o_addr, 8'h00);
    chk("post_rst_data0", o_data, 8'h5A);
    send(8'h6B);
    chk("post_rst_addr1", o_addr, 8'h01);
    s = 8'h5A + 8'h6B;
    finish_frame(s);
    chk("post_rst_done", o_done, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
